// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - button sequencing FSM, tenth-second prescaler and terminal detect for the stopwatch counter
module stopwatch_controller #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic Start,
  input  logic Stop,
  input  logic Clear,
  input  logic Countdown,
  input  logic At_Zero,
  input  logic At_Max,
  output logic Count_Tick,
  output logic Count_Down,
  output logic Clear_Count,
  output logic Load_Preset,
  output logic Running,
  output logic Done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic          start_q, stop_q, clear_q, cdn_q;
  logic          start_e, stop_e, clear_e, cdn_e;
  logic          terminal;
  logic          dir_next, tick_next, clr_next, load_next;

  assign start_e  = Start & ~start_q;
  assign stop_e   = Stop & ~stop_q;
  assign clear_e  = Clear & ~clear_q;
  assign cdn_e    = Countdown & ~cdn_q;
  // The flag that ends a run depends on which way the counter is heading.
  assign terminal = Count_Down ? At_Zero : At_Max;

  // State, prescaler, direction, registered pulses and button history.
  // History resets to 1 so a button held through reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      Count_Down  <= 1'b0;
      Count_Tick  <= 1'b0;
      Clear_Count <= 1'b0;
      Load_Preset <= 1'b0;
      start_q     <= 1'b1;
      stop_q      <= 1'b1;
      clear_q     <= 1'b1;
      cdn_q       <= 1'b1;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      Count_Down  <= dir_next;
      Count_Tick  <= tick_next;
      Clear_Count <= clr_next;
      Load_Preset <= load_next;
      start_q     <= Start;
      stop_q      <= Stop;
      clear_q     <= Clear;
      cdn_q       <= Countdown;
    end
  end

  // Next state: Clear beats everything, then terminal count while running,
  // then only the highest-priority button edge of the cycle is considered.
  always_comb begin
    state_next = state;
    presc_next = presc;
    dir_next   = Count_Down;
    tick_next  = 1'b0;
    clr_next   = 1'b0;
    load_next  = 1'b0;
    if (clear_e) begin
      state_next = IDLE;
      presc_next = '0;
      if (Count_Down) load_next = 1'b1;
      else            clr_next  = 1'b1;
    end else if (state == RUN && terminal) begin
      // Any tick due now is dropped so the counter never wraps.
      state_next = DONE;
    end else begin
      if (state == RUN) begin
        if (presc == LAST) begin
          presc_next = '0;
          tick_next  = 1'b1;
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      if (stop_e) begin
        if (state == RUN) state_next = PAUSE;
      end else if (start_e) begin
        if ((state == IDLE || state == PAUSE) && !terminal) state_next = RUN;
      end else if (cdn_e) begin
        if (state == IDLE) begin
          dir_next = ~Count_Down;
          if (!Count_Down) load_next = 1'b1;
          else             clr_next  = 1'b1;
        end
      end
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    Running = (state == RUN);
    Done    = (state == DONE);
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - self-checking bench for stopwatch_controller
module tb_stopwatch_controller;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0, Stop = 1'b0, Clear = 1'b0, Countdown = 1'b0;
  logic At_Zero = 1'b0, At_Max = 1'b0;
  logic Count_Tick, Count_Down, Clear_Count, Load_Preset, Running, Done;

  int tests = 0;
  int fails = 0;

  stopwatch_controller #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Countdown(Countdown), .At_Zero(At_Zero), .At_Max(At_Max),
    .Count_Tick(Count_Tick), .Count_Down(Count_Down), .Clear_Count(Clear_Count),
    .Load_Preset(Load_Preset), .Running(Running), .Done(Done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done.
  int m_mode, m_pre;
  bit m_dir, m_tick, m_clr, m_load;
  bit p_start, p_stop, p_clear, p_cdn;

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_dir = 0; m_tick = 0; m_clr = 0; m_load = 0;
    p_start = 1; p_stop = 1; p_clear = 1; p_cdn = 1;
  endtask

  task automatic model_step();
    bit es, ep, ec, ed, term;
    es = Start && !p_start;
    ep = Stop && !p_stop;
    ec = Clear && !p_clear;
    ed = Countdown && !p_cdn;
    p_start = Start; p_stop = Stop; p_clear = Clear; p_cdn = Countdown;
    term = m_dir ? At_Zero : At_Max;
    m_tick = 0; m_clr = 0; m_load = 0;
    if (ec) begin
      m_mode = 0; m_pre = 0;
      if (m_dir) m_load = 1; else m_clr = 1;
    end else if (m_mode == 1 && term) begin
      m_mode = 3;
    end else begin
      if (m_mode == 1) begin
        m_pre = (m_pre + 1) % TD;
        m_tick = (m_pre == 0);
      end
      if (ep) begin
        if (m_mode == 1) m_mode = 2;
      end else if (es) begin
        if ((m_mode == 0 || m_mode == 2) && !term) m_mode = 1;
      end else if (ed && m_mode == 0) begin
        m_dir = !m_dir;
        if (m_dir) m_load = 1; else m_clr = 1;
      end
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {Count_Tick, Count_Down, Clear_Count, Load_Preset, Running, Done};
  endfunction

  function automatic logic [5:0] model_outs();
    return {m_tick, m_dir, m_clr, m_load, m_mode == 1, m_mode == 3};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b (tick,dir,clr,load,run,done)", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare #1 later.
  task automatic cyc(input string name);
    @(posedge clk);
    if (!reset) model_step();
    #1;
    check(name, dut_outs(), model_outs());
  endtask

  typedef struct {
    logic st, sp, cl, cd, az, am;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[18];
  int ticks;

  initial begin
    // {start,stop,clear,cdn,at_zero,at_max} -> {tick,dir,clr,load,run,done}
    vt[0]  = '{0,0,0,1,0,0, 6'b010100};
    vt[1]  = '{0,0,0,1,0,0, 6'b010000};
    vt[2]  = '{0,0,0,0,0,0, 6'b010000};
    vt[3]  = '{0,0,0,1,0,0, 6'b001000};
    vt[4]  = '{0,0,0,0,0,0, 6'b000000};
    vt[5]  = '{0,0,0,1,0,0, 6'b010100};
    vt[6]  = '{1,0,0,0,0,0, 6'b010010};
    vt[7]  = '{0,0,0,1,0,0, 6'b010010};
    vt[8]  = '{0,0,0,0,0,0, 6'b010010};
    vt[9]  = '{0,0,0,0,1,0, 6'b010001};
    vt[10] = '{1,0,0,0,1,0, 6'b010001};
    vt[11] = '{0,0,1,0,1,0, 6'b010100};
    vt[12] = '{0,0,0,0,0,0, 6'b010000};
    vt[13] = '{0,0,0,1,0,0, 6'b001000};
    vt[14] = '{1,1,1,0,0,0, 6'b001000};
    vt[15] = '{0,0,0,0,0,0, 6'b000000};
    vt[16] = '{1,0,0,0,0,1, 6'b000000};
    vt[17] = '{0,0,0,0,0,0, 6'b000000};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_outs(), 6'b000000);
    reset = 1'b0;
    cyc("idle_after_reset");

    // Start from IDLE, then ten ticks in forty cycles.
    Start = 1'b1;
    cyc("start");
    check1("running_after_start", Running, 1'b1);
    Start = 1'b0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc("run_count");
      if (Count_Tick) ticks++;
    end
    tests++;
    if (ticks != 10) begin
      fails++;
      $display("FAIL tick_count actual=%0d required=10", ticks);
    end

    // Pause with two prescaler counts held, then resume.
    cyc("pre1");
    Stop = 1'b1;
    cyc("stop");
    Stop = 1'b0;
    check1("paused", Running, 1'b0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("pause_hold");
      if (Count_Tick) ticks++;
    end
    tests++;
    if (ticks != 0) begin
      fails++;
      $display("FAIL pause_ticks actual=%0d required=0", ticks);
    end
    Start = 1'b1;
    cyc("resume");
    Start = 1'b0;
    check1("resume_running", Running, 1'b1);
    cyc("resume_c1");
    check1("resume_no_tick_c1", Count_Tick, 1'b0);
    cyc("resume_c2");
    check1("resume_tick_c2", Count_Tick, 1'b1);

    Clear = 1'b1;
    cyc("clear_run");
    check1("clear_pulse", Clear_Count, 1'b1);
    Clear = 1'b0;
    cyc("clear_done");

    // Directed table: countdown toggling, done, coincident edges, blocked start.
    for (int i = 0; i < 18; i++) begin
      Start = vt[i].st; Stop = vt[i].sp; Clear = vt[i].cl;
      Countdown = vt[i].cd; At_Zero = vt[i].az; At_Max = vt[i].am;
      cyc("table_model");
      check($sformatf("table_%0d", i), dut_outs(), vt[i].exp);
    end

    // Count up into At_Max exactly when a tick is due: no tick, DONE.
    Start = 1'b1;
    cyc("max_start");
    Start = 1'b0;
    repeat (3) cyc("max_run");
    At_Max = 1'b1;
    cyc("max_hit");
    check1("max_done", Done, 1'b1);
    check1("max_no_tick", Count_Tick, 1'b0);
    At_Max = 1'b0;
    Clear = 1'b1;
    cyc("max_clear");
    Clear = 1'b0;
    cyc("max_idle");

    // Asynchronous reset between edges mid-run, Start held through release.
    Start = 1'b1;
    cyc("ar_start");
    cyc("ar_run");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_outs(), 6'b000000);
    model_reset();
    repeat (2) cyc("in_reset");
    reset = 1'b0;
    repeat (3) cyc("held_start");
    check1("held_start_idle", Running, 1'b0);
    Start = 1'b0;
    cyc("release_start");

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      Start     = ($urandom_range(0, 5) == 0);
      Stop      = ($urandom_range(0, 11) == 0);
      Clear     = ($urandom_range(0, 29) == 0);
      Countdown = ($urandom_range(0, 7) == 0);
      At_Zero   = ($urandom_range(0, 19) == 0);
      At_Max    = ($urandom_range(0, 19) == 0);
      cyc("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
